// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared widths and state encoding for the LED blink-code scheduler
package led_pkg;
   localparam int CODE_W = 4;
   localparam int REP_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHOW    = 2'd1,
      ST_RESCHED = 2'd2
   } state_t;
endpackage

// File: rtl/led_code_sched_if.sv
// rtl/led_code_sched_if.sv - requester/flasher signal bundle for led_code_sched
interface led_code_sched_if #(parameter int N_REQ = 4);
   import led_pkg::*;

   logic [N_REQ-1:0]        req;
   logic [CODE_W*N_REQ-1:0] code;
   logic                    seq_done;
   logic [CODE_W-1:0]       flash_cnt;
   logic [N_REQ-1:0]        grant;
   logic [N_REQ-1:0]        served;
   logic                    busy;

   modport master (output req, code, seq_done, input flash_cnt, grant, served, busy);
   modport slave  (input req, code, seq_done, output flash_cnt, grant, served, busy);
endinterface

// File: rtl/led_req_pick.sv
// rtl/led_req_pick.sv - combinational winner select; round-robin from ptr+1 when LED_SCHED_RR_EN is defined
module led_req_pick #(
   parameter int  N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] elig,
`ifdef LED_SCHED_RR_EN
   input  logic [IDX_W-1:0] ptr,
`endif
   output logic [N_REQ-1:0] win,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

`ifdef LED_SCHED_RR_EN
   always_comb begin
      int j;
      win = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      // ptr itself is visited last, so the previous owner has lowest priority
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!any && elig[j]) begin
            win[j] = 1'b1;
            idx    = IDX_W'(j);
            any    = 1'b1;
         end
      end
   end
`else
   always_comb begin
      win = '0;
      idx = '0;
      any = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win    = '0;
            win[i] = 1'b1;
            idx    = IDX_W'(i);
            any    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/led_code_sched.sv
// rtl/led_code_sched.sv - grants the LED flasher to one requester for MIN_REP sequences
// Optional round-robin arbitration via LED_SCHED_RR_EN (fixed lowest-index priority otherwise).
module led_code_sched
   import led_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int MIN_REP = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   led_code_sched_if.slave   bus
);
   localparam int IDX_W = $clog2(N_REQ);

   state_t             state, state_n;
   logic [REP_W-1:0]   rep, rep_n;
   logic [CODE_W-1:0]  flash_q, flash_n;
   logic [N_REQ-1:0]   grant_q, grant_n;
   logic [N_REQ-1:0]   served_q, served_n;
   logic               busy_q, busy_n;

   logic [N_REQ-1:0]   elig;
   logic [N_REQ-1:0]   win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic [CODE_W-1:0]  win_code;
   logic               take;

   // zero codes are masked so an empty blink code can never own the LED
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = bus.req[i] && (bus.code[i*CODE_W +: CODE_W] != '0);
      end
   end

`ifdef LED_SCHED_RR_EN
   logic [IDX_W-1:0] ptr, ptr_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_n;
   end

   led_req_pick #(.N_REQ(N_REQ)) u_pick (
      .elig (elig),
      .ptr  (ptr),
      .win  (win_oh),
      .idx  (win_idx),
      .any  (win_any)
   );
`else
   led_req_pick #(.N_REQ(N_REQ)) u_pick (
      .elig (elig),
      .win  (win_oh),
      .idx  (win_idx),
      .any  (win_any)
   );
`endif

   assign win_code = bus.code[win_idx*CODE_W +: CODE_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rep      <= '0;
         flash_q  <= '0;
         grant_q  <= '0;
         served_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state    <= state_n;
         rep      <= rep_n;
         flash_q  <= flash_n;
         grant_q  <= grant_n;
         served_q <= served_n;
         busy_q   <= busy_n;
      end
   end

   always_comb begin
      state_n  = state;
      rep_n    = rep;
      flash_n  = flash_q;
      grant_n  = grant_q;
      served_n = '0;
      busy_n   = busy_q;
`ifdef LED_SCHED_RR_EN
      ptr_n    = ptr;
`endif
      take     = 1'b0;

      case (state)
         ST_IDLE: begin
            take = win_any;
         end
         ST_SHOW: begin
            if (bus.seq_done && (rep != '0)) begin
               rep_n = rep - 1'b1;
               if (rep == REP_W'(1)) begin
                  state_n  = ST_RESCHED;
                  served_n = grant_q;
                  grant_n  = '0;
               end
            end
         end
         ST_RESCHED: begin
            take = win_any;
            if (!win_any) begin
               state_n = ST_IDLE;
               flash_n = '0;
               busy_n  = 1'b0;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (take) begin
         state_n = ST_SHOW;
         rep_n   = REP_W'(MIN_REP);
         flash_n = win_code;
         grant_n = win_oh;
         busy_n  = 1'b1;
`ifdef LED_SCHED_RR_EN
         ptr_n   = win_idx;
`endif
      end
   end

   assign bus.flash_cnt = flash_q;
   assign bus.grant     = grant_q;
   assign bus.served    = served_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_led_code_sched.sv
// tb/tb_led_code_sched.sv - scoreboard bench for led_code_sched (N_REQ=4, MIN_REP=2)
module tb_led_code_sched;
   typedef struct packed {
      logic [3:0] g;
      logic [3:0] f;
   } gexp_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   gexp_t      gq[$];
   logic [3:0] sq[$];

   led_code_sched_if #(.N_REQ(4)) bus ();

   led_code_sched #(.N_REQ(4), .MIN_REP(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: compare each new grant and each served pulse against the queues
   initial begin
      logic [3:0] prev_g;
      gexp_t      e;
      logic [3:0] s;
      prev_g = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.grant != '0 && prev_g == '0) begin
               if (gq.size() == 0) check("mon_grant_unexpected", bus.grant, 4'h0);
               else begin
                  e = gq.pop_front();
                  check("mon_grant", bus.grant, e.g);
                  check("mon_flash", bus.flash_cnt, e.f);
               end
            end
            if (bus.served != '0) begin
               if (sq.size() == 0) check("mon_served_unexpected", bus.served, 4'h0);
               else begin
                  s = sq.pop_front();
                  check("mon_served", bus.served, s);
               end
            end
         end
         prev_g = bus.grant;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_seq();
      bus.seq_done = 1'b1;
      step();
      bus.seq_done = 1'b0;
   endtask

   // one full grant: 1-cycle latency, two sequences, served pulse; optionally drain to IDLE
   task automatic show(input logic [3:0] g, input logic [3:0] f, input logic last);
      gq.push_back({g, f});
      step();
      check("lat_grant", bus.grant, g);
      check("lat_flash", bus.flash_cnt, f);
      pulse_seq();
      check("mid_grant", bus.grant, g);
      if (last) bus.req = '0;
      sq.push_back(g);
      pulse_seq();
      check("resched_grant", bus.grant, 4'h0);
      check("resched_busy", {3'b0, bus.busy}, 4'h1);
      if (last) begin
         step();
         check("idle_busy", {3'b0, bus.busy}, 4'h0);
         check("idle_flash", bus.flash_cnt, 4'h0);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.req      = '0;
      bus.code     = '0;
      bus.seq_done = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_grant", bus.grant, 4'h0);
      check("rst_flash", bus.flash_cnt, 4'h0);
      check("rst_served", bus.served, 4'h0);
      check("rst_busy", {3'b0, bus.busy}, 4'h0);
      rst_n = 1'b1;
      step();

      // single requester, code 3
      bus.code = 16'h0003;
      bus.req  = 4'b0001;
      show(4'b0001, 4'h3, 1'b0);
      bus.req = '0;
      step();
      check("s1_idle_busy", {3'b0, bus.busy}, 4'h0);
      check("s1_idle_flash", bus.flash_cnt, 4'h0);

      // two held requesters, codes 2 and 5
      bus.code = 16'h0052;
      bus.req  = 4'b0011;
`ifdef LED_SCHED_RR_EN
      show(4'b0010, 4'h5, 1'b0);
      show(4'b0001, 4'h2, 1'b0);
      show(4'b0010, 4'h5, 1'b0);
      show(4'b0001, 4'h2, 1'b1);
`else
      show(4'b0001, 4'h2, 1'b0);
      show(4'b0001, 4'h2, 1'b0);
      show(4'b0001, 4'h2, 1'b0);
      show(4'b0001, 4'h2, 1'b1);
`endif

      // owner changes code and drops req mid-show
      bus.code = 16'h0003;
      bus.req  = 4'b0001;
      gq.push_back({4'b0001, 4'h3});
      step();
      bus.code = 16'h0007;
      bus.req  = '0;
      pulse_seq();
      check("frz_flash1", bus.flash_cnt, 4'h3);
      check("frz_grant", bus.grant, 4'b0001);
      sq.push_back(4'b0001);
      pulse_seq();
      check("frz_flash2", bus.flash_cnt, 4'h3);
      step();
      check("frz_idle_flash", bus.flash_cnt, 4'h0);

      // zero code is never granted
      bus.code = 16'h0000;
      bus.req  = 4'b0100;
      repeat (3) step();
      check("zero_grant", bus.grant, 4'h0);
      check("zero_busy", {3'b0, bus.busy}, 4'h0);
      bus.req = '0;

      // seq_done while idle and together with the new request
      bus.code     = 16'h0003;
      bus.seq_done = 1'b1;
      step();
      step();
      bus.req = 4'b0001;
      gq.push_back({4'b0001, 4'h3});
      step();
      bus.seq_done = 1'b0;
      check("sd_grant", bus.grant, 4'b0001);
      pulse_seq();
      check("sd_grant_after1", bus.grant, 4'b0001);
      check("sd_served_after1", bus.served, 4'h0);
      bus.req = '0;
      sq.push_back(4'b0001);
      pulse_seq();
      check("sd_served_after2", bus.served, 4'b0001);
      step();
      check("sd_idle_busy", {3'b0, bus.busy}, 4'h0);

      // async reset mid-show
      bus.req = 4'b0001;
      gq.push_back({4'b0001, 4'h3});
      step();
      pulse_seq();
      rst_n = 1'b0;
      #1;
      check("ar_grant", bus.grant, 4'h0);
      check("ar_flash", bus.flash_cnt, 4'h0);
      check("ar_busy", {3'b0, bus.busy}, 4'h0);
      check("ar_served", bus.served, 4'h0);
      step();
      rst_n = 1'b1;
      show(4'b0001, 4'h3, 1'b1);

      repeat (2) step();
      check("grant_queue_empty", 4'(gq.size()), 4'h0);
      check("served_queue_empty", 4'(sq.size()), 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
